fixed2float_arbiter: RTL and testbench

- Shares one pipelined fixed-to-float converter (43-bit signed fixed in, 16-bit half-float out, fixed latency, no stall input) among N_REQ requesters, e.g. accumulator lanes.
- Arbitrates requests round-robin and issues at most one conversion per cycle.
- Tracks the requester ID through the converter latency with a tag shift register.
- Buffers results in a credit-protected output FIFO, so a result is never lost when the consumer back-pressures.

---
 rtl/fixed2float_arbiter.sv | 150 +++++++++++++++
 tb/tb_fixed2float_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed2float_arbiter.sv
// rtl/fixed2float_arbiter.sv - shares one pipelined fixed-to-float converter among N_REQ requesters
// Build macro F2F_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module fixed2float_arbiter #(
    parameter int N_REQ        = 4,
    parameter int FIXED_W      = 43,
    parameter int FLOAT_W      = 16,
    parameter int CONV_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8,
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*FIXED_W-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [FIXED_W-1:0]       conv_fixed_out,
    input  logic [FLOAT_W-1:0]       conv_float_in,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [FLOAT_W-1:0]       rsp_data,
    output logic [ID_W-1:0]          rsp_id
);
    // Tag stage 0 sits beside conv_fixed_out; the remaining CONV_LATENCY+1 stages follow the converter.
    localparam int TAG_N = CONV_LATENCY + 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FLT_W = $clog2(TAG_N + 1);

    logic               tag_valid [TAG_N];
    logic [ID_W-1:0]    tag_id    [TAG_N];
    logic [FLOAT_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]    fifo_id   [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic [FLT_W-1:0]   in_flight;
`ifndef F2F_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]    rr_ptr;
`endif

    logic               push;
    logic               pop;
    logic               issue_ok;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    scan_idx;
    logic [FIXED_W-1:0] sel_data;
    int                 space;

    assign push      = tag_valid[TAG_N-1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Credits count both buffered results and conversions still in the pipe.
    always_comb begin
        space     = FIFO_DEPTH - int'(fifo_count) - int'(in_flight);
        issue_ok  = reset_n && (space > 0);
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
`ifdef F2F_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_idx = ID_W'(i);
            if (req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
`else
        for (int i = N_REQ; i >= 1; i--) begin
            scan_idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
            if (req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
`endif
        grant_any = grant_any & issue_ok;
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_any && (grant_id == ID_W'(i))) begin
                sel_data = req_data[i*FIXED_W +: FIXED_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            conv_fixed_out <= '0;
            for (int i = 0; i < TAG_N; i++) begin
                tag_valid[i] <= 1'b0;
                tag_id[i]    <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_flight  <= '0;
`ifndef F2F_ARB_FIXED_PRIO_EN
            rr_ptr     <= ID_W'(N_REQ - 1);
`endif
        end else begin
            conv_fixed_out <= sel_data;
            tag_valid[0]   <= grant_any;
            tag_id[0]      <= grant_any ? grant_id : '0;
            for (int i = 1; i < TAG_N; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
`ifndef F2F_ARB_FIXED_PRIO_EN
            if (grant_any) begin
                rr_ptr <= grant_id;
            end
`endif
            if (grant_any && !push) begin
                in_flight <= in_flight + 1'b1;
            end else if (!grant_any && push) begin
                in_flight <= in_flight - 1'b1;
            end

            if (push) begin
                fifo_data[wr_ptr] <= conv_float_in;
                fifo_id[wr_ptr]   <= tag_id[TAG_N-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // The credit scheme guarantees a landing result always finds a free slot.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (int'(fifo_count) == FIFO_DEPTH)));

endmodule

// File: tb/tb_fixed2float_arbiter.sv
// tb/tb_fixed2float_arbiter.sv - directed table-driven bench for fixed2float_arbiter
module tb_fixed2float_arbiter;
    localparam int N_REQ        = 4;
    localparam int FIXED_W      = 43;
    localparam int FLOAT_W      = 16;
    localparam int CONV_LATENCY = 3;
    localparam int FIFO_DEPTH   = 8;
    localparam int ID_W         = 2;

    logic                     clk;
    logic                     reset_n;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*FIXED_W-1:0] req_data;
    logic [N_REQ-1:0]         req_ready;
    logic [FIXED_W-1:0]       conv_fixed_out;
    logic [FLOAT_W-1:0]       conv_float_in;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [FLOAT_W-1:0]       rsp_data;
    logic [ID_W-1:0]          rsp_id;

    fixed2float_arbiter #(
        .N_REQ(N_REQ), .FIXED_W(FIXED_W), .FLOAT_W(FLOAT_W),
        .CONV_LATENCY(CONV_LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .conv_fixed_out(conv_fixed_out), .conv_float_in(conv_float_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in converter: arbitrary but deterministic mapping, sampled one edge after issue.
    function automatic logic [FLOAT_W-1:0] f2f(input logic [FIXED_W-1:0] x);
        return x[15:0] ^ x[31:16] ^ {5'b0, x[42:32]} ^ 16'h3c00;
    endfunction

    logic [FLOAT_W-1:0] cp [CONV_LATENCY+1];
    always @(posedge clk) begin
        cp[0] <= f2f(conv_fixed_out);
        for (int i = 1; i <= CONV_LATENCY; i++) cp[i] <= cp[i-1];
    end
    assign conv_float_in = cp[CONV_LATENCY];

    typedef struct {
        logic [ID_W-1:0]    id;
        logic [FLOAT_W-1:0] data;
    } rsp_t;

    typedef struct {
        logic [N_REQ-1:0] valid;
        logic             rdy;
        logic [N_REQ-1:0] exp_ready;
    } vec_t;

    rsp_t exp_q[$];
    vec_t vecs [16];
    int   checks;
    int   failures;
    int   grant_cnt;
    int   pop_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Once per cycle: record grants into the scoreboard and check every popped result.
    task automatic observe();
        rsp_t e;
        @(negedge clk);
        if (reset_n) begin
            if (req_ready != '0) begin
                chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
                chk("grant_has_valid", 64'(req_ready & ~req_valid), 64'd0);
                for (int i = 0; i < N_REQ; i++) begin
                    if (req_ready[i] && req_valid[i]) begin
                        e.id   = ID_W'(i);
                        e.data = f2f(req_data[i*FIXED_W +: FIXED_W]);
                        exp_q.push_back(e);
                        grant_cnt++;
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: id=%0d data=%0h with empty scoreboard", rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
        end
    endtask

    task automatic set_data(input int tag);
        for (int i = 0; i < N_REQ; i++)
            req_data[i*FIXED_W +: FIXED_W] = 43'h600_0000_0000 | (43'(tag) << 24) | (43'(tag) << 8) | 43'(i);
    endtask

    task automatic do_reset(input int n);
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            observe();
            step();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; grant_cnt = 0; pop_cnt = 0;
        reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_data = '0;

        for (int r = 0; r < 16; r++) vecs[r].rdy = 1'b1;
        for (int r = 0; r < 10; r++) begin
            vecs[r].valid = 4'hF;
`ifdef F2F_ARB_FIXED_PRIO_EN
            vecs[r].exp_ready = 4'b0001;
`else
            vecs[r].exp_ready = 4'(1 << (r % 4));
`endif
        end
        for (int r = 10; r < 14; r++) begin
            vecs[r].valid = 4'b1010;
`ifdef F2F_ARB_FIXED_PRIO_EN
            vecs[r].exp_ready = 4'b0010;
`else
            vecs[r].exp_ready = (r % 2 == 0) ? 4'b1000 : 4'b0010;
`endif
        end
        vecs[14].valid = 4'b0100; vecs[14].exp_ready = 4'b0100;
        vecs[15].valid = 4'b0000; vecs[15].exp_ready = 4'b0000;

        // Reset values, with requests asserted to show grants are held off during reset
        observe(); step();
        observe(); step();
        req_valid = '1;
        observe();
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_conv_fixed_out", 64'(conv_fixed_out), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        step();

        // Single request: grant, issue, result at t+6
        reset_n = 1'b1;
        req_valid = 4'b0001;
        req_data = '0;
        req_data[FIXED_W-1:0] = 43'h100;
        observe();
        chk("single_grant", 64'(req_ready), 64'd1);
        step();
        req_valid = '0;
        observe();
        chk("single_conv_out", 64'(conv_fixed_out), 64'h100);
        chk("single_rsp_valid_t1", 64'(rsp_valid), 64'd0);
        for (int k = 2; k <= 6; k++) begin
            step();
            observe();
            chk($sformatf("single_rsp_valid_t%0d", k), 64'(rsp_valid), (k == 6) ? 64'd1 : 64'd0);
        end
        chk("single_rsp_id", 64'(rsp_id), 64'd0);
        chk("single_rsp_data", 64'(rsp_data), 64'(f2f(43'h100)));
        step();
        rsp_ready = 1'b1;
        observe();
        step();
        rsp_ready = 1'b0;
        observe();
        chk("single_drained", 64'(rsp_valid), 64'd0);
        step();

        // Arbitration table: full throughput rotation, then requesters 1 and 3 only
        do_reset(1);
        for (int r = 0; r < 16; r++) begin
            req_valid = vecs[r].valid;
            rsp_ready = vecs[r].rdy;
            set_data(100 + r);
            observe();
            chk($sformatf("vec%0d_ready", r), 64'(req_ready), 64'(vecs[r].exp_ready));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            observe();
            step();
        end
        observe();
        chk("table_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("table_rsp_valid_idle", 64'(rsp_valid), 64'd0);
        step();

        // Back-pressure: credits stop grants at FIFO_DEPTH; one pop frees exactly one grant a cycle later
        grant_cnt = 0;
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            set_data(200 + c);
            observe();
            step();
        end
        observe();
        chk("bp_grant_count", 64'(grant_cnt), 64'd8);
        chk("bp_ready_blocked", 64'(req_ready), 64'd0);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        step();
        rsp_ready = 1'b1;
        set_data(230);
        observe();
        chk("bp_no_same_cycle_credit", 64'(req_ready), 64'd0);
        step();
        rsp_ready = 1'b0;
        set_data(231);
        observe();
        chk("bp_regrant_after_pop", 64'($countones(req_ready)), 64'd1);
        step();
        observe();
        chk("bp_blocked_again", 64'(req_ready), 64'd0);
        step();
        for (int c = 0; c < 6; c++) begin
            observe();
            step();
        end
        chk("bp_grant_count_after_pulse", 64'(grant_cnt), 64'd9);
        pop_cnt = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            observe();
            step();
        end
        chk("bp_drain_pops", 64'(pop_cnt), 64'd8);
        chk("bp_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Reset with 3 conversions in flight and 2 results buffered
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_data(300 + i);
            observe();
            step();
        end
        req_valid = '0;
        observe();
        step();
        observe();
        chk("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
        step();
        do_reset(1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            observe();
            chk($sformatf("post_reset_idle%0d", c), 64'(rsp_valid), 64'd0);
            step();
        end
        req_valid = '1;
        set_data(400);
        observe();
        chk("post_reset_first_grant", 64'(req_ready), 64'd1);
        step();
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            observe();
            step();
        end
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
